// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   DATA_WIDTH_DEF : default operand / HI / LO width
//   op_e           : operation encodings presented on the op port
//   state_e        : control FSM states
//   op_is_signed / op_is_div : operation classification helpers
package muldiv_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    case (op)
      OP_MULT, OP_DIV: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_div(input op_e op);
    case (op)
      OP_DIVU, OP_DIV: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between a requester and muldiv_unit.
//   start, op, busA, busB : request side (driven by master)
//   busy, done, hi, lo    : status/result side (driven by slave)
interface muldiv_if #(
  parameter int DATA_WIDTH = muldiv_pkg::DATA_WIDTH_DEF
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] busA;
  logic [DATA_WIDTH-1:0] busB;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (output start, op, busA, busB, input busy, done, hi, lo);
  modport slave  (input start, op, busA, busB, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement negation, used both to take
// operand magnitudes and to restore the sign of results.
//   i_neg : negate when high, pass through when low
//   i_val : input value
//   o_val : i_neg ? -i_val : i_val
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);
  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: one-bit-per-cycle multiplier / restoring divider with HI/LO
// result registers. Signed operations iterate on magnitudes and fix the sign
// of the result on the completion edge.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if.slave (start/op/busA/busB in, busy/done/hi/lo out)
// Build option: define MULDIV_DIV_EN to include the divide datapath; without
// it DIVU/DIV complete in one cycle with hi=lo=0.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  state_e         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_mcand, r_acc_hi, r_acc_lo, r_hi, r_lo;
  logic           r_neg_res, r_busy, r_done;

  op_e            w_op;
  logic           w_neg_a, w_neg_b, w_is_div_op, w_last;
  logic [W-1:0]   w_mag_a, w_mag_b, w_it_hi, w_it_lo, w_res_hi, w_res_lo;
  logic [W:0]     w_sum;
  logic [2*W-1:0] w_prod;

`ifdef MULDIV_DIV_EN
  logic           r_is_div, r_neg_rem, r_div_zero;
  logic [W:0]     w_shift;
  logic [W-1:0]   w_trial, w_quo, w_rem;
`endif

  assign w_op        = op_e'(bus.op);
  assign w_is_div_op = op_is_div(w_op);
  assign w_neg_a     = op_is_signed(w_op) & bus.busA[W-1];
  assign w_neg_b     = op_is_signed(w_op) & bus.busB[W-1];
  assign w_last      = (r_cnt == CW'(1));

  muldiv_negate #(.WIDTH(W)) u_neg_a (.i_neg(w_neg_a), .i_val(bus.busA), .o_val(w_mag_a));
  muldiv_negate #(.WIDTH(W)) u_neg_b (.i_neg(w_neg_b), .i_val(bus.busB), .o_val(w_mag_b));

  // Shift-add step: add multiplicand when the multiplier LSB is set, then
  // shift the (W+1)-bit sum right into the hi:lo accumulator.
  assign w_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : {(W+1){1'b0}});

`ifdef MULDIV_DIV_EN
  // Restoring step: the remainder never exceeds the divisor, so the
  // truncated W-bit difference is exact whenever the trial succeeds.
  assign w_shift = {r_acc_hi, r_acc_lo[W-1]};
  assign w_trial = w_shift[W-1:0] - r_mcand;
`endif

  // One iteration of whichever datapath the latched operation selects.
  always_comb begin
    w_it_hi = w_sum[W:1];
    w_it_lo = {w_sum[0], r_acc_lo[W-1:1]};
`ifdef MULDIV_DIV_EN
    if (r_is_div) begin
      if (w_shift >= {1'b0, r_mcand}) begin
        w_it_hi = w_trial;
        w_it_lo = {r_acc_lo[W-2:0], 1'b1};
      end else begin
        w_it_hi = w_shift[W-1:0];
        w_it_lo = {r_acc_lo[W-2:0], 1'b0};
      end
    end else begin
      w_it_hi = w_sum[W:1];
      w_it_lo = {w_sum[0], r_acc_lo[W-1:1]};
    end
`endif
  end

  muldiv_negate #(.WIDTH(2*W)) u_neg_prod (
    .i_neg(r_neg_res), .i_val({w_it_hi, w_it_lo}), .o_val(w_prod));

`ifdef MULDIV_DIV_EN
  muldiv_negate #(.WIDTH(W)) u_neg_quo (.i_neg(r_neg_res), .i_val(w_it_lo), .o_val(w_quo));
  muldiv_negate #(.WIDTH(W)) u_neg_rem (.i_neg(r_neg_rem), .i_val(w_it_hi), .o_val(w_rem));
`endif

  // Sign-corrected result from the final iteration; divide by zero forces
  // an all-ones quotient while the remainder path already yields the dividend.
  always_comb begin
    w_res_hi = w_prod[2*W-1:W];
    w_res_lo = w_prod[W-1:0];
`ifdef MULDIV_DIV_EN
    if (r_is_div) begin
      w_res_hi = w_rem;
      if (r_div_zero) begin
        w_res_lo = {W{1'b1}};
      end else begin
        w_res_lo = w_quo;
      end
    end else begin
      w_res_hi = w_prod[2*W-1:W];
      w_res_lo = w_prod[W-1:0];
    end
`endif
  end

  // Next-state logic of the IDLE/RUN/DONE controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
`ifdef MULDIV_DIV_EN
          w_state_nxt = ST_RUN;
`else
          if (w_is_div_op) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
          end
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand capture, iteration registers and HI/LO update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= {CW{1'b0}};
      r_mcand    <= {W{1'b0}};
      r_acc_hi   <= {W{1'b0}};
      r_acc_lo   <= {W{1'b0}};
      r_hi       <= {W{1'b0}};
      r_lo       <= {W{1'b0}};
      r_neg_res  <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_is_div   <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_acc_hi  <= {W{1'b0}};
            r_neg_res <= w_neg_a ^ w_neg_b;
`ifdef MULDIV_DIV_EN
            r_is_div   <= w_is_div_op;
            r_neg_rem  <= w_neg_a;
            r_div_zero <= (bus.busB == {W{1'b0}});
            r_mcand    <= w_is_div_op ? w_mag_b : w_mag_a;
            r_acc_lo   <= w_is_div_op ? w_mag_a : w_mag_b;
            r_cnt      <= CW'(W);
`else
            r_mcand  <= w_mag_a;
            r_acc_lo <= w_mag_b;
            if (w_is_div_op) begin
              // Divide not built: complete immediately with a zero result.
              r_cnt <= {CW{1'b0}};
              r_hi  <= {W{1'b0}};
              r_lo  <= {W{1'b0}};
            end else begin
              r_cnt <= CW'(W);
            end
`endif
          end
        end
        ST_RUN: begin
          r_acc_hi <= w_it_hi;
          r_acc_lo <= w_it_lo;
          r_cnt    <= r_cnt - CW'(1);
          if (w_last) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Directed vectors with
// constant expectations, hand-written multi-cycle sequences, and random
// operations compared with an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.DATA_WIDTH(W)) ifc ();
  muldiv_unit #(.DATA_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definition.
  function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] hi_e, output logic [W-1:0] lo_e, output int lat_e);
    logic [63:0] p;
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    lat_e = W + 1;
    case (op)
      2'b00: p = 64'(a) * 64'(b);
      2'b01: p = 64'(sa * sb);
      2'b10: if (b == 32'd0) p = {a, 32'hFFFFFFFF}; else p = {a % b, a / b};
      default: if (b == 32'd0) p = {a, 32'hFFFFFFFF}; else p = {32'(sa % sb), 32'(sa / sb)};
    endcase
    if (op[1] && !DIV_EN) begin
      p = 64'd0;
      lat_e = 1;
    end
    hi_e = p[63:32];
    lo_e = p[31:0];
  endfunction

  // Drives a request now, waits for done (bounded); lat counts edges from acceptance (=1).
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] hi_o, output logic [W-1:0] lo_o, output int lat);
    ifc.start = 1'b1; ifc.op = op; ifc.busA = a; ifc.busB = b;
    @(posedge clk); #1;
    lat = 1;
    ifc.start = 1'b0; ifc.op = 2'($urandom); ifc.busA = $urandom; ifc.busB = $urandom;
    while (!ifc.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    hi_o = ifc.hi;
    lo_o = ifc.lo;
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi_e, input logic [W-1:0] lo_e, input int lat_e);
    logic [W-1:0] hi_g, lo_g;
    int lat;
    run_op(op, a, b, hi_g, lo_g, lat);
    chk({name, "_lat"}, 64'(lat), 64'(lat_e));
    chk({name, "_hi"}, 64'(hi_g), 64'(hi_e));
    chk({name, "_lo"}, 64'(lo_g), 64'(lo_e));
    @(posedge clk); #1;
    chk({name, "_after"}, {62'd0, ifc.busy, ifc.done}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hi_e, lo_e, hi_g, lo_g;
    logic [1:0]   op_r;
    logic [1:0]   rst_ops [2];
    int lat_e, k, ndone, first;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[6]  = '{2'b00, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
    vecs[7]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{2'b10, 32'd9,        32'd3,        32'd0,        32'd3};
    vecs[10] = '{2'b01, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};

    // Reset state, with start held high to show it is ignored during reset.
    ifc.start = 1'b1; ifc.op = 2'b00; ifc.busA = 32'd5; ifc.busB = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy_done", {62'd0, ifc.busy, ifc.done}, 64'd0);
    chk("reset_hilo", {ifc.hi, ifc.lo}, 64'd0);

    // Table vectors; the first starts on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      hi_e = vecs[i].hi; lo_e = vecs[i].lo; lat_e = W + 1;
      if (vecs[i].op[1] && !DIV_EN) begin
        hi_e = 32'd0; lo_e = 32'd0; lat_e = 1;
      end
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, hi_e, lo_e, lat_e);
    end

    // Start pulsed again mid-run is ignored; HI/LO hold previous result meanwhile.
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = 2'b00; ifc.busA = 32'd6; ifc.busB = 32'd7;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ndone = 0; first = 0;
    for (int kk = 2; kk <= 45; kk++) begin
      if (kk == 10) begin
        @(negedge clk);
        ifc.start = 1'b1; ifc.busA = 32'd3; ifc.busB = 32'd3;
      end
      @(posedge clk); #1;
      ifc.start = 1'b0;
      if (kk == 20) chk("hold_hilo", {ifc.hi, ifc.lo}, {32'hFFFFFFFF, 32'hFFFFFFFB});
      if (ifc.done) begin
        ndone++;
        if (first == 0) begin
          first = kk; hi_g = ifc.hi; lo_g = ifc.lo;
        end
      end
    end
    chk("reissue_ndone", 64'(ndone), 64'd1);
    chk("reissue_lat", 64'(first), 64'(W + 1));
    chk("reissue_result", {hi_g, lo_g}, {32'd0, 32'd42});

    // Start during DONE is ignored; the next edge (in IDLE) accepts it.
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = 2'b00; ifc.busA = 32'd2; ifc.busB = 32'd3;
    @(posedge clk); #1;
    ifc.start = 1'b0; k = 1;
    while (!ifc.done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_first_lat", 64'(k), 64'(W + 1));
    chk("b2b_first_lo", 64'(ifc.lo), 64'd6);
    ifc.start = 1'b1; ifc.busA = 32'd11; ifc.busB = 32'd13;
    @(posedge clk); #1;
    chk("b2b_idle_gap", {62'd0, ifc.busy, ifc.done}, 64'd0);
    @(posedge clk); #1;
    ifc.start = 1'b0; k = 2;
    chk("b2b_accepted_busy", 64'(ifc.busy), 64'd1);
    while (!ifc.done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_second_lat", 64'(k), 64'(W + 2));
    chk("b2b_second_result", {ifc.hi, ifc.lo}, {32'd0, 32'd143});
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an operation.
    rst_ops[0] = 2'b10;
    rst_ops[1] = 2'b00;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      do_op($sformatf("rst%0d_setup", r), 2'b00, 32'hFFFFFFFF, 32'd3, 32'd2, 32'hFFFFFFFD, W + 1);
      @(negedge clk);
      ifc.start = 1'b1; ifc.op = rst_ops[r]; ifc.busA = 32'd1000; ifc.busB = 32'd7;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      chk($sformatf("rst%0d_busy_before", r), 64'(ifc.busy), (rst_ops[r][1] && !DIV_EN) ? 64'd0 : 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk($sformatf("rst%0d_flags", r), {62'd0, ifc.busy, ifc.done}, 64'd0);
      chk($sformatf("rst%0d_hilo", r), {ifc.hi, ifc.lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (45) begin
        @(posedge clk); #1;
        if (ifc.done) ndone++;
      end
      chk($sformatf("rst%0d_no_done", r), 64'(ndone), 64'd0);
    end

    // Random operations against the reference model, with some corner operands.
    for (int i = 0; i < 40; i++) begin
      op_r = 2'($urandom_range(0, 3));
      hi_g = $urandom;
      lo_g = $urandom;
      case ($urandom_range(0, 7))
        0: lo_g = 32'd0;
        1: begin hi_g = 32'h80000000; lo_g = 32'hFFFFFFFF; end
        2: begin hi_g = 32'($urandom_range(0, 50)); lo_g = 32'($urandom_range(1, 9)); end
        default: ;
      endcase
      ref_model(op_r, hi_g, lo_g, hi_e, lo_e, lat_e);
      @(negedge clk);
      do_op($sformatf("rnd%0d_op%0d_%h_%h", i, op_r, hi_g, lo_g), op_r, hi_g, lo_g, hi_e, lo_e, lat_e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide parameter: DATA_WIDTH, 32, operand and HI/LO width.
REQ-002 SHALL provide port: clk  input  1  rising-edge clock.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: start  input  1  request, sampled only in IDLE.
REQ-005 SHALL provide port: op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL provide port: busA  input  DATA_WIDTH  multiplicand/dividend, taken from the register file read port A.
REQ-007 SHALL provide port: busB  input  DATA_WIDTH  multiplier/divisor, taken from the register file read port B.
REQ-008 SHALL provide port: busy  output  1  high while an operation is in progress.
REQ-009 SHALL provide port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL provide port: hi  output  DATA_WIDTH  HI result register.
REQ-011 SHALL provide port: lo  output  DATA_WIDTH  LO result register.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL latch busA, busB and op, then enter RUN with iteration counter = DATA_WIDTH, when in IDLE with start=1 at a clock edge.
REQ-014 SHALL perform exactly one shift-add (multiply) or one restoring-subtract (divide) iteration per RUN cycle and decrement the counter.
REQ-015 SHALL go to DONE on the edge at which the counter reaches 0, writing hi/lo on that same edge.
REQ-016 SHALL assert done=1 for exactly the one DONE cycle, then return to IDLE; busy=1 in RUN and DONE only.
REQ-017 SHALL place the first done pulse exactly DATA_WIDTH+1 cycles after the start edge (33 at default); start may be re-asserted during the DONE cycle, and the next accepted start edge is the one leaving DONE->IDLE+1.
REQ-018 SHALL ignore start outside IDLE; ports busA/busB/op may change freely after acceptance.
REQ-019 SHALL hold hi/lo unchanged except on the DONE-entry edge.
REQ-020 SHALL produce hi:lo = full 2*DATA_WIDTH-bit product (two's complement for MULT).
REQ-021 SHALL produce lo = quotient truncated toward zero, hi = remainder with sign of dividend, for DIV/DIVU.
REQ-022 SHALL produce, for signed ops, the result by magnitude iteration with final negation when operand signs require it.
REQ-023 SHALL handle divide-by-zero with no trap: lo = all ones, hi = dividend.
REQ-024 SHALL handle DIV of most-negative by -1 with lo = most-negative, hi = 0.

Reset
REQ-025 SHALL force state=IDLE, counter=0, hi=0, lo=0, busy=0 and done=0 immediately while rst_n=0, including mid-operation, and discard any in-flight result.
REQ-026 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL include divide datapath and DIV/DIVU behaviour as above when macro MULDIV_DIV_EN is defined.
REQ-028 SHALL, without MULDIV_DIV_EN, accept DIV/DIVU, go IDLE->DONE in one cycle with hi=lo=0 and done pulse, with no divide logic synthesised; multiply is unaffected.

Structure
REQ-029 SHALL place op encodings, FSM state enum and DATA_WIDTH default in shared package muldiv_pkg.
REQ-030 SHALL implement conditional two's-complement negation in sub-module muldiv_negate, instantiated for operand and result sign fixup.

Verification
REQ-031 SHALL verify: MULTU busA=0xFFFFFFFF, busB=0xFFFFFFFF -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 SHALL verify: MULT busA=0xFFFFFFFD (-3), busB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-033 SHALL verify: DIV busA=-7, busB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/0 -> lo=0xFFFFFFFF, hi=100.
REQ-034 SHALL verify: start pulsed again at cycle 10 of a running MULTU 6*7 -> ignored, single done, lo=42, hi=0.
REQ-035 SHALL verify: rst_n=0 at cycle 15 of a DIVU -> busy=0, done=0, hi=lo=0 immediately; no done pulse afterwards.
REQ-036 SHALL verify: build without MULDIV_DIV_EN, DIVU 9/3 -> done one cycle after start, hi=lo=0.
